// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write-side arbitration logic.
package fifo_ctrl_pkg;

   typedef enum logic {
      IDLE,
      BURST
   } arb_state_e;

   // Round-robin pointer increment with wrap at n.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority picker: one-hot of the first set request at or after ptr, wrapping.
module fifo_rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic          any
);

   logic [PW-1:0] idx;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
      onehot = '0;
      any    = 1'b0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (!any && req[idx]) begin
            onehot[idx] = 1'b1;
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the Asyncfifo write port among NUM_REQ producers.
module fifo_write_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int data_Size = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                           w_Clk,
   input  logic                           w_Rst,
   input  logic [NUM_REQ-1:0]             req_Valid,
   input  logic [NUM_REQ*data_Size-1:0]   req_Data,
   output logic [NUM_REQ-1:0]             req_Ack,
   output logic [NUM_REQ-1:0]             grant,
   input  logic                           fifo_Full,
   output logic                           w_Inc,
   output logic [data_Size-1:0]           write_Data
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   arb_state_e          state, state_n;
   logic [NUM_REQ-1:0]  grant_n;
   logic [PW-1:0]       rr_ptr, rr_ptr_n;
   logic [CW-1:0]       burst_cnt, burst_cnt_n;

   logic [PW-1:0]       owner, owner_next, pick_ptr;
   logic [NUM_REQ-1:0]  pick_onehot;
   logic                pick_any, owner_valid, acc, burst_end;

   always_comb begin
      owner = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) owner = PW'(i);
   end

   assign owner_next  = PW'(rr_next(int'(owner), NUM_REQ));
   assign owner_valid = |(grant & req_Valid);
   assign acc         = owner_valid & ~fifo_Full;
   assign w_Inc       = acc;
   assign req_Ack     = grant & req_Valid & {NUM_REQ{~fifo_Full}};

   always_comb begin
      write_Data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) write_Data = write_Data | req_Data[i*data_Size +: data_Size];
   end

   // A burst ends on its last permitted beat or as soon as the owner has nothing to offer.
   assign burst_end = (state == BURST) &&
                      (!owner_valid || (acc && burst_cnt == CW'(MAX_BURST - 1)));

   // The single picker serves both the idle pick and the same-cycle re-pick at burst end.
   assign pick_ptr = (state == BURST) ? owner_next : rr_ptr;

   fifo_rr_pick #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_pick (
      .req    (req_Valid),
      .ptr    (pick_ptr),
      .onehot (pick_onehot),
      .any    (pick_any)
   );

   always_comb begin
      state_n     = state;
      grant_n     = grant;
      rr_ptr_n    = rr_ptr;
      burst_cnt_n = burst_cnt;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_n     = BURST;
               grant_n     = pick_onehot;
               burst_cnt_n = '0;
            end
         end
         BURST: begin
            if (burst_end) begin
               rr_ptr_n    = owner_next;
               burst_cnt_n = '0;
               if (pick_any) begin
                  grant_n = pick_onehot;
               end else begin
                  state_n = IDLE;
                  grant_n = '0;
               end
            end else if (acc) begin
               burst_cnt_n = burst_cnt + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge w_Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (w_Rst) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         rr_ptr    <= rr_ptr_n;
         burst_cnt <= burst_cnt_n;
      end
   end

endmodule
